// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Purpose  : Stall/flush sequencer for the 5-stage pipeline with a D-cache
//            timeout watchdog and saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter int REG_ADD_WIDTH = 5,
    parameter int MEM_TIMEOUT   = 64,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [REG_ADD_WIDTH-1:0] i_id_rs1_address,
    input  logic [REG_ADD_WIDTH-1:0] i_id_rs2_address,
    input  logic                     i_id_rs1_used,
    input  logic                     i_id_rs2_used,
    input  logic [REG_ADD_WIDTH-1:0] i_ex_rd_address,
    input  logic                     i_ex_load,
    input  logic                     i_branch_taken,
    input  logic                     i_icache_ready,
    input  logic                     i_dcache_req,
    input  logic                     i_dcache_ready,
    output logic                     o_pc_stall,
    output logic                     o_stall_fetch,
    output logic                     o_clear_fetch,
    output logic                     o_stall_decode,
    output logic                     o_clear_decode,
    output logic                     o_stall_execution_stage,
    output logic                     o_stall_memory,
    output logic                     o_clear_memory,
    output logic                     o_mem_error,
    output logic [CNT_WIDTH-1:0]     o_stall_cycle_count,
    output logic [CNT_WIDTH-1:0]     o_flush_count
);

    localparam int c_WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERROR    = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [c_WAIT_W-1:0]   r_wait_cnt;
    logic [c_WAIT_W-1:0]   w_wait_cnt_next;
    logic [c_WAIT_W-1:0]   w_wait_cnt_inc;
    logic                  r_mem_error;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;
    logic [CNT_WIDTH-1:0]  r_flush_cnt;

    logic w_req_pend;
    logic w_memwait;
    logic w_load_use;
    logic w_timeout;
    logic w_flush_evt;
    logic w_pc_stall;
    logic w_stall_fetch;
    logic w_clear_fetch;
    logic w_stall_decode;
    logic w_clear_decode;
    logic w_stall_ex;
    logic w_stall_mem;
    logic w_clear_mem;

    always_comb begin
        w_req_pend = i_dcache_req & ~i_dcache_ready;
        w_memwait  = (r_state == S_ERROR) | w_req_pend;
        w_load_use = i_ex_load & (i_ex_rd_address != '0) &
                     ((i_id_rs1_used & (i_id_rs1_address == i_ex_rd_address)) |
                      (i_id_rs2_used & (i_id_rs2_address == i_ex_rd_address)));

        // The count includes the current not-ready cycle, so the watchdog
        // trips at the edge closing the MEM_TIMEOUT-th consecutive wait cycle.
        if (r_state == S_RUN) begin
            w_wait_cnt_inc = c_WAIT_W'(1);
        end else if (r_wait_cnt == '1) begin
            w_wait_cnt_inc = r_wait_cnt;
        end else begin
            w_wait_cnt_inc = r_wait_cnt + 1'b1;
        end
        w_timeout = (MEM_TIMEOUT != 0) && (w_wait_cnt_inc == c_WAIT_W'(MEM_TIMEOUT));
    end

    always_comb begin
        w_next_state    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            S_RUN, S_MEM_WAIT: begin
                if (w_req_pend) begin
                    w_next_state    = w_timeout ? S_ERROR : S_MEM_WAIT;
                    w_wait_cnt_next = w_wait_cnt_inc;
                end else begin
                    // Release, or the request vanished without READY.
                    w_next_state    = S_RUN;
                    w_wait_cnt_next = '0;
                end
            end
            S_ERROR: begin
                w_next_state = S_ERROR;
            end
            default: begin
                w_next_state    = S_RUN;
                w_wait_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        w_pc_stall     = 1'b0;
        w_stall_fetch  = 1'b0;
        w_clear_fetch  = 1'b0;
        w_stall_decode = 1'b0;
        w_clear_decode = 1'b0;
        w_stall_ex     = 1'b0;
        w_stall_mem    = 1'b0;
        w_clear_mem    = 1'b0;
        w_flush_evt    = 1'b0;
        if (w_memwait) begin
            w_pc_stall     = 1'b1;
            w_stall_fetch  = 1'b1;
            w_stall_decode = 1'b1;
            w_stall_ex     = 1'b1;
            w_stall_mem    = 1'b1;
            w_clear_mem    = 1'b1;
        end else if (i_branch_taken) begin
            w_clear_fetch  = 1'b1;
            w_clear_decode = 1'b1;
            w_flush_evt    = 1'b1;
        end else if (w_load_use) begin
            w_pc_stall     = 1'b1;
            w_stall_fetch  = 1'b1;
            w_clear_decode = 1'b1;
        end else if (!i_icache_ready) begin
            w_pc_stall     = 1'b1;
            w_clear_fetch  = 1'b1;
        end
    end

    // Reset forces the pipeline to hold the PC and flush every stage.
    always_comb begin
        o_pc_stall              = ~i_rst_n | w_pc_stall;
        o_stall_fetch           =  i_rst_n & w_stall_fetch;
        o_clear_fetch           = ~i_rst_n | w_clear_fetch;
        o_stall_decode          =  i_rst_n & w_stall_decode;
        o_clear_decode          = ~i_rst_n | w_clear_decode;
        o_stall_execution_stage =  i_rst_n & w_stall_ex;
        o_stall_memory          =  i_rst_n & w_stall_mem;
        o_clear_memory          = ~i_rst_n | w_clear_mem;
        o_mem_error             = r_mem_error;
        o_stall_cycle_count     = r_stall_cnt;
        o_flush_count           = r_flush_cnt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= '0;
            r_mem_error <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_next_state == S_ERROR) begin
                r_mem_error <= 1'b1;
            end
            if (w_pc_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_controller
// Purpose  : Scoreboard bench; two DUT configurations share one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       ld;
        logic       br;
        logic       ic;
        logic       req;
        logic       rdy;
    } stim_t;

    typedef struct packed {
        logic [7:0]  ctl0;
        logic [7:0]  ctl1;
        logic        err0;
        logic        err1;
        logic [63:0] sc0;
        logic [63:0] sc1;
        logic [63:0] fc0;
        logic [63:0] fc1;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       u1 = 1'b0, u2 = 1'b0, ld = 1'b0, br = 1'b0;
    logic       ic = 1'b1, req = 1'b0, rdy = 1'b0;

    logic [7:0]  ctl_a, ctl_b;
    logic        err_a, err_b;
    logic [31:0] sc_a, fc_a;
    logic [3:0]  sc_b, fc_b;

    exp_t   sb[$];
    int     n_vec  = 0;
    int     n_miss = 0;

    int     m_run[2];
    bit     m_err[2];
    longint m_sc[2];
    longint m_fc[2];

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.REG_ADD_WIDTH(5), .MEM_TIMEOUT(16), .CNT_WIDTH(32)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_rs1_address(rs1), .i_id_rs2_address(rs2),
        .i_id_rs1_used(u1), .i_id_rs2_used(u2),
        .i_ex_rd_address(rd), .i_ex_load(ld), .i_branch_taken(br),
        .i_icache_ready(ic), .i_dcache_req(req), .i_dcache_ready(rdy),
        .o_pc_stall(ctl_a[7]), .o_stall_fetch(ctl_a[6]), .o_clear_fetch(ctl_a[5]),
        .o_stall_decode(ctl_a[4]), .o_clear_decode(ctl_a[3]),
        .o_stall_execution_stage(ctl_a[2]), .o_stall_memory(ctl_a[1]),
        .o_clear_memory(ctl_a[0]), .o_mem_error(err_a),
        .o_stall_cycle_count(sc_a), .o_flush_count(fc_a)
    );

    pipeline_hazard_controller #(.REG_ADD_WIDTH(5), .MEM_TIMEOUT(0), .CNT_WIDTH(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_id_rs1_address(rs1), .i_id_rs2_address(rs2),
        .i_id_rs1_used(u1), .i_id_rs2_used(u2),
        .i_ex_rd_address(rd), .i_ex_load(ld), .i_branch_taken(br),
        .i_icache_ready(ic), .i_dcache_req(req), .i_dcache_ready(rdy),
        .o_pc_stall(ctl_b[7]), .o_stall_fetch(ctl_b[6]), .o_clear_fetch(ctl_b[5]),
        .o_stall_decode(ctl_b[4]), .o_clear_decode(ctl_b[3]),
        .o_stall_execution_stage(ctl_b[2]), .o_stall_memory(ctl_b[1]),
        .o_clear_memory(ctl_b[0]), .o_mem_error(err_b),
        .o_stall_cycle_count(sc_b), .o_flush_count(fc_b)
    );

    // Bit order {pc_stall, stall_fetch, clear_fetch, stall_decode, clear_decode,
    //            stall_ex, stall_mem, clear_mem}.
    function automatic logic [7:0] exp_ctl(bit err, stim_t s);
        bit lu;
        lu = s.ld && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        if (!s.rst_n)                 return 8'b1010_1001;
        else if (err || (s.req && !s.rdy)) return 8'b1101_0111;
        else if (s.br)                return 8'b0010_1000;
        else if (lu)                  return 8'b1100_1000;
        else if (!s.ic)               return 8'b1010_0000;
        else                          return 8'b0000_0000;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        s.ic    = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t   e;
        logic [7:0] c [2];
        int     to;
        longint maxc;
        @(posedge clk);
        #1;
        rst_n = s.rst_n; rs1 = s.rs1; rs2 = s.rs2; u1 = s.u1; u2 = s.u2;
        rd = s.rd; ld = s.ld; br = s.br; ic = s.ic; req = s.req; rdy = s.rdy;
        for (int i = 0; i < 2; i++) c[i] = exp_ctl(m_err[i], s);
        e.ctl0 = c[0];     e.ctl1 = c[1];
        e.err0 = m_err[0]; e.err1 = m_err[1];
        e.sc0  = m_sc[0];  e.sc1  = m_sc[1];
        e.fc0  = m_fc[0];  e.fc1  = m_fc[1];
        sb.push_back(e);
        for (int i = 0; i < 2; i++) begin
            to   = (i == 0) ? 16 : 0;
            maxc = (i == 0) ? 64'hFFFF_FFFF : 64'd15;
            if (!s.rst_n) begin
                m_run[i] = 0; m_err[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
            end else begin
                if (c[i][7] && m_sc[i] < maxc) m_sc[i]++;
                if (!m_err[i] && !(s.req && !s.rdy) && s.br && m_fc[i] < maxc) m_fc[i]++;
                if (!m_err[i]) begin
                    if (s.req && !s.rdy) begin
                        m_run[i]++;
                        if (to != 0 && m_run[i] == to) m_err[i] = 1;
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("ctl_a",   {56'd0, ctl_a}, {56'd0, e.ctl0});
            check("ctl_b",   {56'd0, ctl_b}, {56'd0, e.ctl1});
            check("err_a",   {63'd0, err_a}, {63'd0, e.err0});
            check("err_b",   {63'd0, err_b}, {63'd0, e.err1});
            check("stall_a", {32'd0, sc_a},  e.sc0);
            check("stall_b", {60'd0, sc_b},  e.sc1);
            check("flush_a", {32'd0, fc_a},  e.fc0);
            check("flush_b", {60'd0, fc_b},  e.fc1);
        end
    end

    initial begin
        stim_t s;
        bit    pend;
        int    p_rdy;
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_err[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end

        s = idle(); s.rst_n = 1'b0;
        repeat (2) apply(s);

        // Load-use on rs2, then the same with rd = x0
        s = idle(); s.ld = 1; s.rd = 5; s.rs2 = 5; s.u2 = 1;
        apply(s);
        s.rd = 0; s.rs2 = 0;
        apply(s);
        apply(idle());

        // Load-use coincident with a taken branch
        s = idle(); s.ld = 1; s.rd = 7; s.rs1 = 7; s.u1 = 1; s.br = 1;
        apply(s);
        apply(idle());

        // Three not-ready cycles then completion
        s = idle(); s.req = 1;
        repeat (3) apply(s);
        s.rdy = 1;
        apply(s);
        repeat (2) apply(idle());

        // Watchdog: request never completes, READY afterwards is ignored
        s = idle(); s.req = 1;
        repeat (18) apply(s);
        s.rdy = 1; s.br = 1;
        repeat (3) apply(s);
        s = idle(); s.rst_n = 0;
        apply(s);
        apply(idle());

        // Reset pulse in the middle of a wait
        s = idle(); s.req = 1;
        repeat (5) apply(s);
        s.rst_n = 0;
        apply(s);
        repeat (2) apply(idle());

        // I-miss saturation, then I-miss together with load-use
        s = idle(); s.ic = 0;
        repeat (20) apply(s);
        s.ld = 1; s.rd = 3; s.rs1 = 3; s.u1 = 1;
        repeat (2) apply(s);

        // Randomized traffic; requests are held until READY as a real stage would
        pend  = 0;
        p_rdy = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) p_rdy = (p_rdy == 50) ? 3 : 50;
            s       = idle();
            s.rst_n = ($urandom_range(0, 79) != 0);
            s.rs1   = 5'($urandom_range(0, 3));
            s.rs2   = 5'($urandom_range(0, 3));
            s.rd    = 5'($urandom_range(0, 3));
            s.u1    = 1'($urandom);
            s.u2    = 1'($urandom);
            s.ld    = 1'($urandom);
            s.br    = ($urandom_range(0, 3) == 0);
            s.ic    = ($urandom_range(0, 3) != 0);
            s.req   = pend ? ($urandom_range(0, 49) != 0) : ($urandom_range(0, 2) == 0);
            s.rdy   = ($urandom_range(0, 99) < p_rdy);
            pend    = s.rst_n && s.req && !s.rdy;
            apply(s);
        end

        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
